serial_to_parallel: RTL

- Deserializer sitting directly downstream of parallel_to_serial.
- Consumes its serial_valid/serial_data bit stream, sent LSB first, and reassembles words of `width` bits.
- Presents each completed word on a valid/ready output with a one-word holding register.
- Flags words lost to downstream backpressure; supports a synchronous abort of a partial word.

---
 rtl/s2p_pkg.sv | 8 +
 rtl/s2p_out_reg.sv | 40 ++++
 rtl/serial_to_parallel.sv | 65 ++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// s2p_pkg: collector state encoding and bit-counter sizing shared by
// serial_to_parallel and its bench.
package s2p_pkg;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PARITY} s2p_state_t;
  function automatic int s2p_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/s2p_out_reg.sv
// s2p_out_reg: one-entry valid/ready holding register; a load that finds the
// entry full and not draining is dropped and reported by a one-cycle drop pulse.
module s2p_out_reg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [width-1:0] load_data,
  input  logic             load_err,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data,
  output logic             err,
  output logic             drop
);
  logic             valid_q, valid_d, err_q, drop_q, take;
  logic [width-1:0] data_q;
  assign take    = load_valid && (!valid_q || ready);
  assign valid_d = take || (valid_q && !ready);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      drop_q  <= load_valid && !take;
      if (take) begin
        data_q <= load_data;
        err_q  <= load_err;
      end
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
  assign err   = err_q;
  assign drop  = drop_q;
endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: LSB-first bit-stream deserializer with a one-word output
// buffer. Define S2P_PARITY_EN for a trailing even-parity bit per word.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  input  logic             clear,
  input  logic             parallel_ready,
  output logic             parallel_valid,
  output logic [width-1:0] parallel_data,
  output logic             parity_err,
  output logic             overflow,
  output logic             collecting
);
  localparam int cnt_w = s2p_cnt_w(width);
  s2p_state_t       state_q;
  logic [cnt_w-1:0] bit_cnt_q;
  logic [width-1:0] shift_q, word;
  logic             acc, last_data, done, err;
  assign acc       = serial_valid && !clear;
  assign last_data = acc && state_q == S_COLLECT && bit_cnt_q == cnt_w'(width - 1);
`ifdef S2P_PARITY_EN
  assign done = acc && state_q == S_PARITY;
  assign word = shift_q;
  assign err  = ^shift_q ^ serial_data;
`else
  logic unused_lsb;
  assign unused_lsb = shift_q[0];
  assign done = last_data;
  assign word = {serial_data, shift_q[width-1:1]};
  assign err  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (clear) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
    end else if (serial_valid) begin
      shift_q   <= {serial_data, shift_q[width-1:1]};
      bit_cnt_q <= done ? '0 : bit_cnt_q + cnt_w'(1);
      state_q   <= done ? S_IDLE : last_data ? S_PARITY : S_COLLECT;
    end
  end
  assign collecting = bit_cnt_q != '0;
  s2p_out_reg #(.width(width)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load_valid(done),
    .load_data (word),
    .load_err  (err),
    .ready     (parallel_ready),
    .valid     (parallel_valid),
    .data      (parallel_data),
    .err       (parity_err),
    .drop      (overflow)
  );
endmodule
